// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes, control FSM states
// and small op-classification helpers used by the control path.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLT   = 4'd5,
    OP_SLTU  = 4'd6,
    OP_SLL   = 4'd7,
    OP_SRL   = 4'd8,
    OP_SRA   = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULHU = 4'd11,
    OP_DIVU  = 4'd12,
    OP_REMU  = 4'd13
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } alu_state_e;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned shift-add multiplier and restoring divider, one bit per cycle.
// done pulses on the last iteration cycle; the outputs then carry that final step's value.
module muldiv_iter #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] mul_lo,
  output logic [DATA_WIDTH-1:0] mul_hi,
  output logic [DATA_WIDTH-1:0] quo,
  output logic [DATA_WIDTH-1:0] rem
);

  logic [2*DATA_WIDTH-1:0] prod_r;
  logic [2*DATA_WIDTH-1:0] prod_nxt_s;
  logic [DATA_WIDTH-1:0]   opnd_r;
  logic [DATA_WIDTH-1:0]   quo_r;
  logic [DATA_WIDTH-1:0]   rem_r;
  logic [DATA_WIDTH-1:0]   quo_nxt_s;
  logic [DATA_WIDTH-1:0]   rem_nxt_s;
  logic [DATA_WIDTH:0]     sum_s;
  logic [DATA_WIDTH:0]     rem_sh_s;
  logic [CNT_W-1:0]        cnt_r;

  // One multiply step and one divide step; divide by zero falls out as all-ones / dividend.
  always_comb begin
    sum_s      = {1'b0, prod_r[2*DATA_WIDTH-1:DATA_WIDTH]}
               + (prod_r[0] ? {1'b0, opnd_r} : {(DATA_WIDTH+1){1'b0}});
    prod_nxt_s = {sum_s, prod_r[DATA_WIDTH-1:1]};
    rem_sh_s   = {rem_r, quo_r[DATA_WIDTH-1]};
    if (rem_sh_s >= {1'b0, opnd_r}) begin
      rem_nxt_s = rem_sh_s[DATA_WIDTH-1:0] - opnd_r;
      quo_nxt_s = {quo_r[DATA_WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt_s = rem_sh_s[DATA_WIDTH-1:0];
      quo_nxt_s = {quo_r[DATA_WIDTH-2:0], 1'b0};
    end
  end

  // Operand load on start, then DATA_WIDTH iteration cycles counted down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r <= {(2*DATA_WIDTH){1'b0}};
      opnd_r <= {DATA_WIDTH{1'b0}};
      quo_r  <= {DATA_WIDTH{1'b0}};
      rem_r  <= {DATA_WIDTH{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
    end else if (start) begin
      prod_r <= {{DATA_WIDTH{1'b0}}, b};
      opnd_r <= is_div ? b : a;
      quo_r  <= a;
      rem_r  <= {DATA_WIDTH{1'b0}};
      cnt_r  <= CNT_W'(DATA_WIDTH);
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      prod_r <= prod_nxt_s;
      quo_r  <= quo_nxt_s;
      rem_r  <= rem_nxt_s;
      cnt_r  <= cnt_r - CNT_W'(1);
    end
  end

  assign done   = (cnt_r == CNT_W'(1));
  assign mul_lo = prod_nxt_s[DATA_WIDTH-1:0];
  assign mul_hi = prod_nxt_s[2*DATA_WIDTH-1:DATA_WIDTH];
  assign quo    = quo_nxt_s;
  assign rem    = rem_nxt_s;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes: single-cycle ops return on the accept edge,
// MUL/MULHU/DIVU/REMU run through muldiv_iter for DATA_WIDTH cycles.
module seq_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  eq,
  output logic                  lt,
  output logic                  ltu
);

  localparam int SHW = $clog2(DATA_WIDTH);

  alu_state_e            state_r;
  alu_state_e            state_nxt_s;
  logic [3:0]            op_r;
  logic [DATA_WIDTH-1:0] a_r;
  logic [DATA_WIDTH-1:0] b_r;
  logic                  accept_s;
  logic                  start_s;
  logic                  md_done_s;
  logic [DATA_WIDTH-1:0] mul_lo_s;
  logic [DATA_WIDTH-1:0] mul_hi_s;
  logic [DATA_WIDTH-1:0] quo_s;
  logic [DATA_WIDTH-1:0] rem_s;
  logic [DATA_WIDTH-1:0] single_res_s;
  logic [DATA_WIDTH-1:0] md_res_s;
  logic                  lt_in_s;
  logic                  ltu_in_s;
  logic                  out_valid_r;
  logic                  out_valid_nxt_s;
  logic [DATA_WIDTH-1:0] result_r;
  logic [DATA_WIDTH-1:0] result_nxt_s;
  logic                  eq_r;
  logic                  lt_r;
  logic                  ltu_r;
  logic                  eq_nxt_s;
  logic                  lt_nxt_s;
  logic                  ltu_nxt_s;

  // A finished result may drain on the same edge a new op is accepted.
  assign in_ready = (state_r == ST_IDLE) && (!out_valid_r || out_ready);
  assign accept_s = in_valid && in_ready;
  assign start_s  = accept_s && is_iter_op(op);
  assign lt_in_s  = $signed(a) < $signed(b);
  assign ltu_in_s = a < b;

  muldiv_iter #(
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_W     (CNT_W)
  ) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_s),
    .is_div(is_div_op(op)),
    .a     (a),
    .b     (b),
    .done  (md_done_s),
    .mul_lo(mul_lo_s),
    .mul_hi(mul_hi_s),
    .quo   (quo_s),
    .rem   (rem_s)
  );

  // Single-cycle datapath on the incoming operands; unknown codes yield zero.
  always_comb begin
    single_res_s = {DATA_WIDTH{1'b0}};
    case (alu_op_e'(op))
      OP_ADD:  single_res_s = a + b;
      OP_SUB:  single_res_s = a - b;
      OP_AND:  single_res_s = a & b;
      OP_OR:   single_res_s = a | b;
      OP_XOR:  single_res_s = a ^ b;
      OP_SLT:  single_res_s = {{(DATA_WIDTH-1){1'b0}}, lt_in_s};
      OP_SLTU: single_res_s = {{(DATA_WIDTH-1){1'b0}}, ltu_in_s};
      OP_SLL:  single_res_s = a << b[SHW-1:0];
      OP_SRL:  single_res_s = a >> b[SHW-1:0];
      OP_SRA:  single_res_s = $unsigned($signed(a) >>> b[SHW-1:0]);
      default: single_res_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  // Pick the iterative unit's output according to the captured op.
  always_comb begin
    md_res_s = {DATA_WIDTH{1'b0}};
    case (alu_op_e'(op_r))
      OP_MUL:   md_res_s = mul_lo_s;
      OP_MULHU: md_res_s = mul_hi_s;
      OP_DIVU:  md_res_s = quo_s;
      OP_REMU:  md_res_s = rem_s;
      default:  md_res_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  // Control FSM next state; single-cycle ops never leave IDLE so they can stream.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nxt_s = is_div_op(op) ? ST_DIV : ST_MUL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (md_done_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output register next values: new result, drain, or hold.
  always_comb begin
    out_valid_nxt_s = out_valid_r;
    result_nxt_s    = result_r;
    eq_nxt_s        = eq_r;
    lt_nxt_s        = lt_r;
    ltu_nxt_s       = ltu_r;
    if (accept_s && !is_iter_op(op)) begin
      out_valid_nxt_s = 1'b1;
      result_nxt_s    = single_res_s;
      eq_nxt_s        = (a == b);
      lt_nxt_s        = lt_in_s;
      ltu_nxt_s       = ltu_in_s;
    end else if ((state_r == ST_MUL || state_r == ST_DIV) && md_done_s) begin
      out_valid_nxt_s = 1'b1;
      result_nxt_s    = md_res_s;
      eq_nxt_s        = (a_r == b_r);
      lt_nxt_s        = $signed(a_r) < $signed(b_r);
      ltu_nxt_s       = a_r < b_r;
    end else if (out_valid_r && out_ready) begin
      out_valid_nxt_s = 1'b0;
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
  end

  // State and captured operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      op_r    <= 4'd0;
      a_r     <= {DATA_WIDTH{1'b0}};
      b_r     <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        op_r <= op;
        a_r  <= a;
        b_r  <= b;
      end
    end
  end

  // Registered result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      result_r    <= {DATA_WIDTH{1'b0}};
      eq_r        <= 1'b0;
      lt_r        <= 1'b0;
      ltu_r       <= 1'b0;
    end else begin
      out_valid_r <= out_valid_nxt_s;
      result_r    <= result_nxt_s;
      eq_r        <= eq_nxt_s;
      lt_r        <= lt_nxt_s;
      ltu_r       <= ltu_nxt_s;
    end
  end

  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign eq        = eq_r;
  assign lt        = lt_r;
  assign ltu       = ltu_r;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner cases then randomized ops
// compared against an arithmetic reference model.
module tb_seq_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = 32'd0;
  logic [W-1:0] b = 32'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         eq;
  logic         lt;
  logic         ltu;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_alu #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .eq       (eq),
    .lt       (lt),
    .ltu      (ltu)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_res(input logic [3:0] o, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
    logic [63:0]         p;
    logic signed [W-1:0] sx;
    p  = {32'd0, x} * {32'd0, y};
    sx = x;
    case (o)
      4'd0:  return x + y;
      4'd1:  return x - y;
      4'd2:  return x & y;
      4'd3:  return x | y;
      4'd4:  return x ^ y;
      4'd5:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd6:  return (x < y) ? 32'd1 : 32'd0;
      4'd7:  return x << y[4:0];
      4'd8:  return x >> y[4:0];
      4'd9:  return sx >>> y[4:0];
      4'd10: return p[31:0];
      4'd11: return p[63:32];
      4'd12: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      4'd13: return (y == 32'd0) ? x : x % y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, measure latency, check result/flags, hold for `hold` cycles, then drain.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int hold);
    logic [W-1:0] er;
    logic [2:0]   ef;
    int           lat;
    int           expl;
    er   = model_res(o, x, y);
    ef   = {x == y, $signed(x) < $signed(y), x < y};
    expl = (o >= 4'd10 && o <= 4'd13) ? W + 1 : 1;
    @(negedge clk);
    check("in_ready_idle", {63'd0, in_ready}, 64'd1);
    in_valid  = 1'b1;
    op        = o;
    a         = x;
    b         = y;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = 4'($urandom);
    a        = $urandom;
    b        = $urandom;
    lat      = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("latency op%0d", o), 64'(lat), 64'(expl));
    check($sformatf("result op%0d a=%0h b=%0h", o, x, y), {32'd0, result}, {32'd0, er});
    check($sformatf("flags op%0d", o), {61'd0, eq, lt, ltu}, {61'd0, ef});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold", {27'd0, out_valid, in_ready, eq, lt, ltu, result},
            {27'd0, 1'b1, 1'b0, ef, er});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("drain", {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  initial begin
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {28'd0, out_valid, eq, lt, ltu, result}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", {63'd0, in_ready}, 64'd1);

    // Directed corner cases
    run_op(4'd0,  32'hFFFF_FFFF, 32'd1, 1);
    run_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    run_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(4'd12, 32'd100, 32'd0, 0);
    run_op(4'd13, 32'd100, 32'd0, 0);
    run_op(4'd12, 32'd100, 32'd7, 0);
    run_op(4'd13, 32'd100, 32'd7, 0);
    run_op(4'd5,  32'hFFFF_FFFF, 32'd1, 5);
    run_op(4'd9,  32'h8000_0000, 32'd35, 0);
    run_op(4'd15, 32'd5, 32'd5, 0);

    // Back-to-back ADDs, one result per cycle
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op        = 4'd0;
    for (int i = 0; i < 6; i++) begin
      x = $urandom;
      y = $urandom;
      a = x;
      b = y;
      @(posedge clk);
      #1;
      check("b2b_add", {31'd0, out_valid, result}, {31'd0, 1'b1, x + y});
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_drain", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b0;

    // Reset in the middle of a DIVU
    @(negedge clk);
    in_valid = 1'b1;
    op       = 4'd12;
    a        = 32'd100;
    b        = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_mid_div", {27'd0, out_valid, in_ready, eq, lt, ltu, result},
          {27'd0, 1'b0, 1'b1, 3'd0, 32'd0});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_release", {63'd0, in_ready}, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("no_stale_result", {63'd0, seen}, 64'd0);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      run_op(4'($urandom_range(0, 15)), pick(), pick(), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
